// File: rtl/block_band_scheduler.sv
// Band scheduler: buffers BLOCK_SIZE raster rows, then emits them as BLOCK_SIZE x BLOCK_SIZE blocks.
// Optional macro BLOCK_LEVEL_SHIFT_EN stores pixels level-shifted to signed (pix - 2^(PIX_WIDTH-1)).
module block_band_scheduler #(
    parameter int unsigned IMG_ROWS        = 480,
    parameter int unsigned IMG_COLS        = 640,
    parameter int unsigned BLOCK_SIZE      = 8,
    parameter int unsigned LOG2_BLOCK_SIZE = 3,
    parameter int unsigned PIX_WIDTH       = 8,
    parameter int unsigned ROW_CTR_WIDTH   = 9,
    parameter int unsigned COL_CTR_WIDTH   = 10
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   start_img,
    input  logic                                                   pix_valid,
    input  logic [PIX_WIDTH-1:0]                                   pix_data,
    output logic                                                   pix_ready,
    output logic                                                   blk_valid,
    input  logic                                                   blk_ready,
    output logic [BLOCK_SIZE*BLOCK_SIZE*(PIX_WIDTH+1)-1:0]         blk_data,
    output logic [ROW_CTR_WIDTH-LOG2_BLOCK_SIZE-1:0]               blk_row,
    output logic [COL_CTR_WIDTH-LOG2_BLOCK_SIZE-1:0]               blk_col,
    output logic                                                   blk_last,
    output logic                                                   img_done,
    output logic                                                   busy
);

    localparam int unsigned EW  = PIX_WIDTH + 1;
    localparam int unsigned BRW = ROW_CTR_WIDTH - LOG2_BLOCK_SIZE;
    localparam int unsigned BCW = COL_CTR_WIDTH - LOG2_BLOCK_SIZE;
    localparam int unsigned NBR = IMG_ROWS / BLOCK_SIZE;
    localparam int unsigned NBC = IMG_COLS / BLOCK_SIZE;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]               state_q,   state_d;
    logic [ROW_CTR_WIDTH-1:0] row_q,     row_d;
    logic [COL_CTR_WIDTH-1:0] col_q,     col_d;
    logic [BRW-1:0]           blk_row_q, blk_row_d;
    logic [BCW-1:0]           blk_col_q, blk_col_d;

    logic [EW-1:0] line_buf [BLOCK_SIZE][IMG_COLS];
    logic [EW-1:0] wr_elem;
    logic          pix_acc;
    logic          blk_hs;

    // Handshake and status outputs are pure decodes of the state register.
    assign pix_ready = (state_q == FILL);
    assign blk_valid = (state_q == DRAIN);
    assign img_done  = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign blk_row   = blk_row_q;
    assign blk_col   = blk_col_q;
    assign blk_last  = blk_valid && (blk_row_q == BRW'(NBR - 1)) && (blk_col_q == BCW'(NBC - 1));

    assign pix_acc = pix_valid && pix_ready;
    assign blk_hs  = blk_valid && blk_ready;

`ifdef BLOCK_LEVEL_SHIFT_EN
    assign wr_elem = {1'b0, pix_data} - (EW'(1) << (PIX_WIDTH - 1));
`else
    assign wr_elem = {1'b0, pix_data};
`endif

    // Line buffer has no reset; every slot is rewritten before it is drained.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            line_buf[row_q[LOG2_BLOCK_SIZE-1:0]][col_q] <= wr_elem;
        end
    end

    // Gather the current block's columns out of the band; forced to zero outside DRAIN.
    always_comb begin
        blk_data = '0;
        if (blk_valid) begin
            for (int unsigned r = 0; r < BLOCK_SIZE; r++) begin
                for (int unsigned c = 0; c < BLOCK_SIZE; c++) begin
                    blk_data[(r*BLOCK_SIZE + c)*EW +: EW] =
                        line_buf[LOG2_BLOCK_SIZE'(r)][{blk_col_q, LOG2_BLOCK_SIZE'(c)}];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            blk_row_q <= '0;
            blk_col_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            blk_row_q <= blk_row_d;
            blk_col_q <= blk_col_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        blk_row_d = blk_row_q;
        blk_col_d = blk_col_q;
        case (state_q)
            IDLE: begin
                if (start_img) begin
                    state_d   = FILL;
                    row_d     = '0;
                    col_d     = '0;
                    blk_row_d = '0;
                    blk_col_d = '0;
                end
            end
            FILL: begin
                if (pix_acc) begin
                    if (col_q == COL_CTR_WIDTH'(IMG_COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_CTR_WIDTH'(1);
                        if (row_q[LOG2_BLOCK_SIZE-1:0] == LOG2_BLOCK_SIZE'(BLOCK_SIZE - 1)) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        col_d = col_q + COL_CTR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (blk_hs) begin
                    if (blk_col_q == BCW'(NBC - 1)) begin
                        blk_col_d = '0;
                        if (blk_row_q == BRW'(NBR - 1)) begin
                            state_d = DONE;
                        end else begin
                            blk_row_d = blk_row_q + BRW'(1);
                            state_d   = FILL;
                        end
                    end else begin
                        blk_col_d = blk_col_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
